// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Memory-bus and instruction-handshake bundle for instr_fetch.
//               The master modport is the fetch unit. The slave modport is the
//               memory/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  // memory space side
  logic [15:0] MAB_out;
  logic [15:0] MDB_in;
  logic        MW;
  logic        BW;
  logic        bus_grant;
  logic        fetch_req;
  // redirect from the execution side
  logic        PC_load;
  logic [15:0] PC_new;
  // instruction consumer side
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] IR_out;
  logic [15:0] IR_addr;

  modport master (
    output MAB_out, MW, BW, fetch_req, ir_valid, IR_out, IR_addr,
    input  MDB_in, bus_grant, PC_load, PC_new, ir_ready
  );

  modport slave (
    input  MAB_out, MW, BW, fetch_req, ir_valid, IR_out, IR_addr,
    output MDB_in, bus_grant, PC_load, PC_new, ir_ready
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Sequential instruction prefetcher with a DEPTH-entry queue.
//               Optional macro FETCH_RESET_VECTOR_EN makes reset start with a
//               vector read from 16'hFFFE instead of starting at RESET_PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'hC000
) (
  input  wire            clk,
  input  wire            rst,
  instr_fetch_if.master  bus
);

  localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [15:0] C_VECTOR  = 16'hFFFE;
  localparam logic [15:0] C_EVEN    = 16'hFFFE;

  typedef enum logic [0:0] {
    ST_VEC = 1'b0,
    ST_RUN = 1'b1
  } state_t;

`ifdef FETCH_RESET_VECTOR_EN
  localparam state_t C_RST_STATE = ST_VEC;
`else
  localparam state_t C_RST_STATE = ST_RUN;
`endif

  state_t          state_q;
  logic [15:0]     fetch_pc_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [31:0]     entry_q [DEPTH];   // {addr, word}

  logic            do_fetch;
  logic            do_push;
  logic            do_pop;
  logic            head_valid;
  logic [31:0]     head_entry;

  // Fetch/push/pop decisions; fullness uses the count at cycle start so a
  // same-cycle pop cannot unlock a fetch.
  always_comb begin
    head_valid = !rst && (state_q == ST_RUN) && (count_q != '0);
    do_fetch   = !rst && bus.bus_grant && !bus.PC_load &&
                 ((state_q == ST_VEC) || (count_q < C_FULL));
    do_push    = do_fetch && (state_q == ST_RUN);
    do_pop     = head_valid && bus.ir_ready;
    head_entry = entry_q[rd_ptr_q];
  end

  assign bus.MAB_out   = (state_q == ST_VEC) ? C_VECTOR : fetch_pc_q;
  assign bus.MW        = 1'b0;
  assign bus.BW        = 1'b0;
  assign bus.fetch_req = do_fetch;
  assign bus.ir_valid  = head_valid;
  // Outputs come only from queue storage; reset forces them to zero at once.
  assign bus.IR_out    = rst ? 16'h0000 : head_entry[15:0];
  assign bus.IR_addr   = rst ? 16'h0000 : head_entry[31:16];

  // FSM, fetch pointer and queue bookkeeping; redirect beats every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_RST_STATE;
      fetch_pc_q <= RESET_PC & C_EVEN;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= 32'h0;
      end
    end else if (bus.PC_load) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= bus.PC_new & C_EVEN;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (do_fetch && (state_q == ST_VEC)) begin
        fetch_pc_q <= bus.MDB_in & C_EVEN;
        state_q    <= ST_RUN;
      end
      if (do_push) begin
        entry_q[wr_ptr_q] <= {fetch_pc_q, bus.MDB_in};
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        fetch_pc_q        <= fetch_pc_q + 16'd2;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch (DEPTH=2,
//               RESET_PC=16'hC000). Memory returns 16'hC010 at 16'hFFFE and
//               addr ^ 16'hA5A5 elsewhere.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  instr_fetch_if bus ();

  instr_fetch #(
    .DEPTH    (2),
    .RESET_PC (16'hC000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational memory, data valid in the same cycle as the address
  assign bus.MDB_in = (bus.MAB_out == 16'hFFFE) ? 16'hC010 : (bus.MAB_out ^ 16'hA5A5);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.bus_grant = 1'b1;
    bus.ir_ready  = 1'b0;
    bus.PC_load   = 1'b0;
    bus.PC_new    = 16'h0000;

    // ---- reset ----
    tick(); tick();
    #1;
    chk("rst_fetch_req", {15'h0, bus.fetch_req}, 16'h0);
    chk("rst_ir_valid",  {15'h0, bus.ir_valid},  16'h0);
    chk("rst_IR_out",    bus.IR_out,  16'h0000);
    chk("rst_IR_addr",   bus.IR_addr, 16'h0000);
    chk("MW_tied",       {15'h0, bus.MW}, 16'h0);
    chk("BW_tied",       {15'h0, bus.BW}, 16'h0);

    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_IR_out",  bus.IR_out,  16'h0000);
    chk("post_rst_IR_addr", bus.IR_addr, 16'h0000);
    chk("post_rst_valid",   {15'h0, bus.ir_valid}, 16'h0);

`ifdef FETCH_RESET_VECTOR_EN
    // vector read then first sequential fetch at C010
    chk("vec_MAB",       bus.MAB_out, 16'hFFFE);
    chk("vec_fetch_req", {15'h0, bus.fetch_req}, 16'h1);
    tick();
    chk("vec_next_MAB",  bus.MAB_out, 16'hC010);
    chk("vec_valid0",    {15'h0, bus.ir_valid}, 16'h0);
    tick();
    chk("vec_valid1",    {15'h0, bus.ir_valid}, 16'h1);
    chk("vec_IR_addr",   bus.IR_addr, 16'hC010);
    // redirect to C000 so the common sequence below applies
    bus.PC_load = 1'b1;
    bus.PC_new  = 16'hC000;
    tick();
    bus.PC_load = 1'b0;
    #1;
`endif

    // ---- fill with ir_ready=0 ----
    chk("f0_MAB",       bus.MAB_out, 16'hC000);
    chk("f0_fetch_req", {15'h0, bus.fetch_req}, 16'h1);
    tick();
    chk("f1_valid",     {15'h0, bus.ir_valid}, 16'h1);
    chk("f1_IR_addr",   bus.IR_addr, 16'hC000);
    chk("f1_IR_out",    bus.IR_out,  16'h65A5);
    chk("f1_MAB",       bus.MAB_out, 16'hC002);
    chk("f1_fetch_req", {15'h0, bus.fetch_req}, 16'h1);
    tick();
    chk("full_fetch_req", {15'h0, bus.fetch_req}, 16'h0);
    chk("full_MAB",       bus.MAB_out, 16'hC004);
    tick();
    chk("full_hold_req",  {15'h0, bus.fetch_req}, 16'h0);
    chk("full_hold_addr", bus.IR_addr, 16'hC000);

    // ---- pop while full: no fetch this cycle ----
    bus.ir_ready = 1'b1;
    #1;
    chk("pop_full_req", {15'h0, bus.fetch_req}, 16'h0);
    tick();
    bus.ir_ready = 1'b0;
    #1;
    chk("pop_IR_addr",   bus.IR_addr, 16'hC002);
    chk("pop_IR_out",    bus.IR_out,  16'h65A7);
    chk("resume_req",    {15'h0, bus.fetch_req}, 16'h1);
    chk("resume_MAB",    bus.MAB_out, 16'hC004);
    tick();   // queue: C002, C004

    // ---- bus_grant low for 3 cycles, draining ----
    bus.bus_grant = 1'b0;
    bus.ir_ready  = 1'b1;
    #1;
    chk("ng0_req", {15'h0, bus.fetch_req}, 16'h0);
    tick();
    chk("ng1_req",  {15'h0, bus.fetch_req}, 16'h0);
    chk("ng1_addr", bus.IR_addr, 16'hC004);
    tick();
    chk("ng2_valid", {15'h0, bus.ir_valid}, 16'h0);
    tick();
    chk("ng3_valid", {15'h0, bus.ir_valid}, 16'h0);
    chk("ng3_MAB",   bus.MAB_out, 16'hC006);
    bus.bus_grant = 1'b1;
    bus.ir_ready  = 1'b0;
    tick(); tick();   // queue: C006, C008
    chk("pre_ld_addr", bus.IR_addr, 16'hC006);
    chk("pre_ld_req",  {15'h0, bus.fetch_req}, 16'h0);

    // ---- redirect with full queue ----
    bus.PC_load  = 1'b1;
    bus.PC_new   = 16'hE123;
    bus.ir_ready = 1'b1;
    #1;
    chk("ld_req", {15'h0, bus.fetch_req}, 16'h0);
    tick();
    bus.PC_load  = 1'b0;
    bus.ir_ready = 1'b0;
    #1;
    chk("ld_valid0", {15'h0, bus.ir_valid}, 16'h0);
    chk("ld_MAB",    bus.MAB_out, 16'hE122);
    tick();
    chk("ld_valid1", {15'h0, bus.ir_valid}, 16'h1);
    chk("ld_addr",   bus.IR_addr, 16'hE122);

    // ---- wrap at FFFE ----
    bus.PC_load = 1'b1;
    bus.PC_new  = 16'hFFFF;
    tick();
    bus.PC_load = 1'b0;
    #1;
    chk("wrap_MAB0", bus.MAB_out, 16'hFFFE);
    tick();
    chk("wrap_addr", bus.IR_addr, 16'hFFFE);
    chk("wrap_out",  bus.IR_out,  16'hC010);
    chk("wrap_MAB1", bus.MAB_out, 16'h0000);
    tick();   // queue: FFFE, 0000
    chk("wrap_full", {15'h0, bus.fetch_req}, 16'h0);

    // ---- reset mid-run, overriding PC_load ----
    rst         = 1'b1;
    bus.PC_load = 1'b1;
    bus.PC_new  = 16'h1234;
    #1;
    chk("mrst_req",   {15'h0, bus.fetch_req}, 16'h0);
    chk("mrst_valid", {15'h0, bus.ir_valid}, 16'h0);
    chk("mrst_out",   bus.IR_out, 16'h0000);
    tick();
    rst         = 1'b0;
    bus.PC_load = 1'b0;
    #1;
    chk("mrst_valid1", {15'h0, bus.ir_valid}, 16'h0);
    chk("mrst_out1",   bus.IR_out,  16'h0000);
    chk("mrst_addr1",  bus.IR_addr, 16'h0000);
`ifdef FETCH_RESET_VECTOR_EN
    chk("mrst_MAB", bus.MAB_out, 16'hFFFE);
    tick();
    chk("mrst_vec_MAB",   bus.MAB_out, 16'hC010);
    chk("mrst_vec_valid", {15'h0, bus.ir_valid}, 16'h0);
    tick();
    chk("mrst_vec_addr",  bus.IR_addr, 16'hC010);
`else
    chk("mrst_MAB", bus.MAB_out, 16'hC000);
    chk("mrst_req1", {15'h0, bus.fetch_req}, 16'h1);
    tick();
    chk("mrst_run_addr", bus.IR_addr, 16'hC000);
    chk("mrst_run_out",  bus.IR_out,  16'h65A5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
